weight_addr_tiled: RTL and testbench

Parametrised successor to the single-stream weight address generator. After a `start` pulse it produces the full sequence of weight-memory read addresses for one convolution layer, with a valid/ready output handshake and a selectable ordering. In `mode` 0 addresses are kernel-major and linear. In `mode` 1 they are interleaved across `PE_COLS` kernels, so one beat feeds the same element to each column of the GEMM PE array. It sits between the layer controller and the weight SRAM read port.

---
 rtl/weight_addr_tiled_pkg.sv | 24 ++
 rtl/weight_addr_cnt.sv | 28 ++
 rtl/weight_addr_tiled.sv | 182 ++++++++++++++++++
 tb/tb_weight_addr_tiled.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_addr_tiled_pkg.sv
// Shared widths, mode encodings and FSM state type for the tiled weight
// address generator.
package weight_addr_tiled_pkg;

  localparam int ADDR_SIZE        = 16;
  localparam int KERNEL_SIZE      = 4;
  localparam int CHANNELS_SIZE    = 8;
  localparam int KERNEL_NUMS_SIZE = 8;

  localparam logic WADDR_MODE_LINEAR = 1'b0;
  localparam logic WADDR_MODE_PE     = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } waddr_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/weight_addr_cnt.sv
// Generic wrap counter: counts 0..limit-1 on en, flags the terminal count and
// pulses wrap when the terminal count is consumed.
module weight_addr_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign last = (cnt == limit - ONE);
  assign wrap = en & last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= last ? '0 : cnt + ONE;
  end

endmodule

// File: rtl/weight_addr_tiled.sv
// Weight-memory read address generator for one conv layer, linear or
// interleaved across PE_COLS kernels, with a valid/ready output.
module weight_addr_tiled
  import weight_addr_tiled_pkg::*;
#(
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int KSIZE_W = KERNEL_SIZE,
  parameter int CH_W    = CHANNELS_SIZE,
  parameter int KNUM_W  = KERNEL_NUMS_SIZE,
  parameter int PE_COLS = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [KSIZE_W-1:0] kernel_size,
  input  logic [CH_W-1:0]    channels,
  input  logic [KNUM_W-1:0]  kernel_nums,
  input  logic               o_ready,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_valid,
  output logic               o_last,
  output logic               busy,
  output logic               done
);

  localparam int EW = 2 * KSIZE_W + CH_W;
  localparam int LW = $clog2(PE_COLS + 1);
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);

  waddr_state_e state, nstate;

  logic               mode_r;
  logic [ADDR_W-1:0]  base_r;
  logic [KSIZE_W-1:0] k_r;
  logic [CH_W-1:0]    c_r;
  logic [KNUM_W-1:0]  n_r;

  logic [EW-1:0]      e_r;
  logic [ADDR_W-1:0]  e_step_r;
  logic [ADDR_W-1:0]  grp_step_r;
  logic [KNUM_W-1:0]  grp_lim_r;
  logic [LW-1:0]      lanes_full_r;
  logic [LW-1:0]      lanes_last_r;

  logic [ADDR_W-1:0]  addr_r, row_r, grp_r;

  logic [EW-1:0]      e_calc;
  logic               zero_c;
  logic               fire;
  logic [LW-1:0]      lane_lim;
  logic               lane_last, lane_wrap;
  logic               elem_last, elem_wrap;
  logic               grp_last, grp_wrap;

  assign e_calc = EW'(k_r) * EW'(k_r) * EW'(c_r);
  assign zero_c = (k_r == '0) || (c_r == '0) || (n_r == '0);
  assign fire   = (state == S_RUN) && o_ready;

  // Only the final group may be partially populated; its lane count is
  // precomputed so empty lanes are skipped without bubbles.
  assign lane_lim = grp_last ? lanes_last_r : lanes_full_r;

  // Linear mode is the interleaved walk with a single lane and step E.
  weight_addr_cnt #(.W(LW)) u_lane_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state == S_SETUP),
    .en   (fire),
    .limit(lane_lim),
    .last (lane_last),
    .wrap (lane_wrap)
  );

  weight_addr_cnt #(.W(EW)) u_elem_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state == S_SETUP),
    .en   (lane_wrap),
    .limit(e_r),
    .last (elem_last),
    .wrap (elem_wrap)
  );

  weight_addr_cnt #(.W(KNUM_W)) u_grp_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state == S_SETUP),
    .en   (elem_wrap),
    .limit(grp_lim_r),
    .last (grp_last),
    .wrap (grp_wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = S_SETUP;
      S_SETUP: nstate = zero_c ? S_DONE : S_RUN;
      S_RUN:   if (grp_wrap) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r       <= WADDR_MODE_LINEAR;
      base_r       <= '0;
      k_r          <= '0;
      c_r          <= '0;
      n_r          <= '0;
      e_r          <= '0;
      e_step_r     <= '0;
      grp_step_r   <= '0;
      grp_lim_r    <= '0;
      lanes_full_r <= '0;
      lanes_last_r <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_r <= mode;
        base_r <= base_addr;
        k_r    <= kernel_size;
        c_r    <= channels;
        n_r    <= kernel_nums;
      end
      if (state == S_SETUP) begin
        e_r      <= e_calc;
        e_step_r <= ADDR_W'(e_calc);
        if (mode_r == WADDR_MODE_PE) begin
          grp_lim_r    <= KNUM_W'(ceil_div(int'(n_r), PE_COLS));
          lanes_full_r <= LW'(PE_COLS);
          lanes_last_r <= LW'(int'(n_r) - (ceil_div(int'(n_r), PE_COLS) - 1) * PE_COLS);
          grp_step_r   <= ADDR_W'(PE_COLS * int'(e_calc));
        end else begin
          grp_lim_r    <= n_r;
          lanes_full_r <= LW'(1);
          lanes_last_r <= LW'(1);
          grp_step_r   <= ADDR_W'(e_calc);
        end
      end
    end
  end

  // grp_r: first address of the current group; row_r: lane 0 of the current
  // element; addr_r: the beat on the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r <= '0;
      row_r  <= '0;
      grp_r  <= '0;
    end else if (state == S_SETUP) begin
      addr_r <= base_r;
      row_r  <= base_r;
      grp_r  <= base_r;
    end else if (fire && !grp_wrap) begin
      if (elem_wrap) begin
        grp_r  <= grp_r + grp_step_r;
        row_r  <= grp_r + grp_step_r;
        addr_r <= grp_r + grp_step_r;
      end else if (lane_wrap) begin
        row_r  <= row_r + AONE;
        addr_r <= row_r + AONE;
      end else begin
        addr_r <= addr_r + e_step_r;
      end
    end
  end

  assign o_addr  = addr_r;
  assign o_valid = (state == S_RUN);
  assign o_last  = (state == S_RUN) && lane_last && elem_last && grp_last;
  assign busy    = (state == S_SETUP) || (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_weight_addr_tiled.sv
// Bench for weight_addr_tiled: table of layer configs plus random configs,
// each beat compared against a nested-loop reference of the memory layout.
module tb_weight_addr_tiled;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] base_addr = '0;
  logic [3:0]  kernel_size = '0;
  logic [7:0]  channels = '0;
  logic [7:0]  kernel_nums = '0;
  logic        o_ready = 1'b0;
  logic [15:0] o_addr;
  logic        o_valid, o_last, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_addr[$];
  logic        exp_last[$];

  typedef struct {
    logic        md;
    logic [15:0] base;
    logic [3:0]  k;
    logic [7:0]  c;
    logic [7:0]  n;
    int          rdy;
    int          beats;
  } vec_t;

  vec_t tbl[10];

  weight_addr_tiled #(.PE_COLS(P)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .mode       (mode),
    .base_addr  (base_addr),
    .kernel_size(kernel_size),
    .channels   (channels),
    .kernel_nums(kernel_nums),
    .o_ready    (o_ready),
    .o_addr     (o_addr),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic scramble();
    mode        = 1'($urandom);
    base_addr   = 16'($urandom);
    kernel_size = 4'($urandom);
    channels    = 8'($urandom);
    kernel_nums = 8'($urandom);
  endtask

  // Kernel n element e lives at base + n*E + e; mode 1 walks group, element,
  // lane and drops lanes beyond the last kernel.
  task automatic build_model(input logic md, input logic [15:0] base,
                             input logic [3:0] k, input logic [7:0] c, input logic [7:0] n);
    int e_sz, nk, g_cnt;
    exp_addr.delete();
    exp_last.delete();
    e_sz = int'(k) * int'(k) * int'(c);
    nk   = int'(n);
    if (e_sz == 0 || nk == 0) return;
    if (md == 1'b0) begin
      for (int kk = 0; kk < nk; kk++)
        for (int e = 0; e < e_sz; e++) begin
          exp_addr.push_back(16'(int'(base) + kk * e_sz + e));
          exp_last.push_back(1'b0);
        end
    end else begin
      g_cnt = (nk + P - 1) / P;
      for (int g = 0; g < g_cnt; g++)
        for (int e = 0; e < e_sz; e++)
          for (int l = 0; l < P; l++)
            if (g * P + l < nk) begin
              exp_addr.push_back(16'(int'(base) + (g * P + l) * e_sz + e));
              exp_last.push_back(1'b0);
            end
    end
    exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  // Called at posedge+1 with the DUT idle; returns one cycle after done.
  task automatic run_cfg(input string tag, input logic md, input logic [15:0] base,
                         input logic [3:0] k, input logic [7:0] c, input logic [7:0] n,
                         input int rdy_pct, input int beats);
    int cyc, xfers, vcyc, last_x, budget, eb;
    bit stalled, got_done;
    logic [15:0] prev_addr, ea;
    logic prev_last, el;
    build_model(md, base, k, c, n);
    eb = (beats < 0) ? exp_addr.size() : beats;
    cyc = 1; xfers = 0; vcyc = 0; last_x = 0; stalled = 0; got_done = 0;
    prev_addr = '0; prev_last = 1'b0;
    budget = 30 * eb + 30;
    mode = md; base_addr = base; kernel_size = k; channels = c; kernel_nums = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_valid_t1"}, o_valid, 0);
    while (!got_done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) chk({tag, "_first_t2"}, (eb == 0) ? done : o_valid, 1);
      if (stalled) begin
        chk({tag, "_stall_valid"}, o_valid, 1);
        chk({tag, "_stall_addr"}, o_addr, prev_addr);
        chk({tag, "_stall_last"}, o_last, prev_last);
      end
      if (o_valid) vcyc++;
      if (done) begin
        got_done = 1;
        chk({tag, "_busy_in_done"}, busy, 0);
      end else begin
        o_ready = ($urandom_range(99) < rdy_pct);
        start   = ($urandom_range(3) == 0);
        scramble();
        if (o_valid && o_ready) begin
          xfers++;
          last_x = cyc;
          if (exp_addr.size() == 0) chk({tag, "_extra_beat"}, o_addr, -1);
          else begin
            ea = exp_addr.pop_front();
            el = exp_last.pop_front();
            chk({tag, "_addr"}, o_addr, ea);
            chk({tag, "_last"}, o_last, el);
          end
        end
        stalled   = o_valid && !o_ready;
        prev_addr = o_addr;
        prev_last = o_last;
      end
    end
    if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
    else chk({tag, "_done_cycle"}, cyc, (eb == 0) ? 2 : last_x + 1);
    chk({tag, "_transfers"}, xfers, eb);
    if (eb == 0) chk({tag, "_no_valid"}, vcyc, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_start_in_done_ignored"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 4'd2, 8'd3, 8'd10, 100, 120};
    tbl[1] = '{1'b1, 16'h0000, 4'd1, 8'd2, 8'd6,  100, 12};
    tbl[2] = '{1'b1, 16'h0000, 4'd1, 8'd2, 8'd6,  45,  12};
    tbl[3] = '{1'b0, 16'h0000, 4'd2, 8'd0, 8'd5,  100, 0};
    tbl[4] = '{1'b1, 16'h0000, 4'd0, 8'd3, 8'd5,  100, 0};
    tbl[5] = '{1'b0, 16'h0000, 4'd2, 8'd3, 8'd0,  100, 0};
    tbl[6] = '{1'b0, 16'hFFFE, 4'd1, 8'd1, 8'd4,  100, 4};
    tbl[7] = '{1'b1, 16'hFFF0, 4'd2, 8'd2, 8'd7,  70,  56};
    tbl[8] = '{1'b1, 16'd100,  4'd3, 8'd1, 8'd4,  100, 36};
    tbl[9] = '{1'b1, 16'd5,    4'd1, 8'd1, 8'd1,  60,  1};

    #12;
    chk("reset_addr", o_addr, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_last", o_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_cfg($sformatf("tbl%0d", i), tbl[i].md, tbl[i].base, tbl[i].k, tbl[i].c,
              tbl[i].n, tbl[i].rdy, tbl[i].beats);

    // Abort after five beats: outputs clear asynchronously and no done follows.
    mode = 1'b0; base_addr = 16'h0; kernel_size = 4'd2; channels = 8'd3; kernel_nums = 8'd10;
    o_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("midrun_addr_before_reset", o_addr, 5);
    #1 rstn = 1'b0;
    #1;
    chk("midrun_reset_addr", o_addr, 0);
    chk("midrun_reset_valid", o_valid, 0);
    chk("midrun_reset_last", o_last, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    repeat (2) begin @(posedge clk); #1; chk("midrun_held_done", done, 0); end
    @(negedge clk) rstn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_release_done", done, 0);
      chk("post_release_busy", busy, 0);
    end
    run_cfg("post_reset", 1'b0, 16'h0, 4'd2, 8'd3, 8'd10, 100, 120);

    for (int i = 0; i < 20; i++)
      run_cfg($sformatf("rnd%0d", i), 1'($urandom), 16'($urandom),
              4'($urandom_range(3)), 8'($urandom_range(4)), 8'($urandom_range(9)),
              $urandom_range(100, 30), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
